tvp_sync_meas: RTL and testbench

- Input-side timing measurement stage on the TVP7002 pixel clock domain.
- Consumes the latched HSYNC/VSYNC/FID that feed the scan converter, then measures line period, sync width, lines per frame, pixels per frame and interlace.
- Publishes stable, registered timing status for the CPU status word and the scan converter mode logic.
- Sits between the input latch stage and the scan converter.

---
 rtl/tvp_meas_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/tvp_sync_meas.sv | 169 ++++++++++++++++
 tb/tb_tvp_sync_meas.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tvp_meas_pkg.sv
// Shared constants and helpers for the TVP7002 input timing measurement block.
// Provides default counter widths, an all-ones helper used to derive the
// saturation limits of each counter, and an absolute-difference function used
// for the line-period tolerance compare.
package tvp_meas_pkg;

    localparam int unsigned H_CNT_W_DEF = 12;
    localparam int unsigned V_CNT_W_DEF = 11;
    localparam int unsigned F_CNT_W_DEF = 20;

    // All-ones value of a w-bit counter (w < 32); this is its saturation point.
    function automatic int unsigned sat_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Sync polarity normaliser and edge detector.
// Ports:
//   clk      - pixel clock
//   reset    - synchronous, active-high reset
//   sync_raw - latched sync input at its native polarity
//   rise     - leading (activating) edge of the sync pulse, combinational
//   fall     - trailing (deactivating) edge of the sync pulse, combinational
module sync_edge_det #(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sync_raw,
    output logic rise,
    output logic fall
);

    logic lvl;
    logic lvl_q;

    // Normalised to active-high regardless of source polarity.
    assign lvl = sync_raw ^ ACT_LOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    always_comb begin
        rise = lvl & ~lvl_q;
        fall = ~lvl & lvl_q;
    end

endmodule

// File: rtl/tvp_sync_meas.sv
// Input-side timing measurement on the TVP7002 pixel clock domain.
// Measures line period, HSYNC width, lines per frame/field, pixels per frame
// and interlace from the latched syncs, and publishes registered status.
// Ports:
//   PCLK_in    - pixel clock (sole clock)
//   reset      - synchronous, active-high reset
//   HSYNC_in   - latched horizontal sync
//   VSYNC_in   - latched vertical sync
//   FID_in     - latched field ID
//   hperiod    - PCLKs between HSYNC leading edges, last line (0 after timeout)
//   hswidth    - PCLKs HSYNC was active, last line
//   vtotal     - lines in last frame/field (max of both fields when interlaced)
//   pcnt_frame - PCLKs between VSYNC leading edges
//   ilace_flag - FID toggled across the last two VSYNC edges
//   h_unstable - line period not yet settled, or lost
//   v_valid    - a full frame has been measured with no timeout since
//   frame_stb  - one-cycle pulse coincident with frame output updates
module tvp_sync_meas
    import tvp_meas_pkg::*;
#(
    parameter int unsigned H_CNT_W      = H_CNT_W_DEF,
    parameter int unsigned V_CNT_W      = V_CNT_W_DEF,
    parameter int unsigned F_CNT_W      = F_CNT_W_DEF,
    parameter int unsigned H_TOL        = 2,
    parameter int unsigned STABLE_LINES = 8,
    parameter bit          SYNC_ACT_LOW = 1'b1
) (
    input  logic               PCLK_in,
    input  logic               reset,
    input  logic               HSYNC_in,
    input  logic               VSYNC_in,
    input  logic               FID_in,
    output logic [H_CNT_W-1:0] hperiod,
    output logic [H_CNT_W-1:0] hswidth,
    output logic [V_CNT_W-1:0] vtotal,
    output logic [F_CNT_W-1:0] pcnt_frame,
    output logic               ilace_flag,
    output logic               h_unstable,
    output logic               v_valid,
    output logic               frame_stb
);

    localparam logic [H_CNT_W-1:0] H_MAX = H_CNT_W'(sat_max(H_CNT_W));
    localparam logic [V_CNT_W-1:0] V_MAX = V_CNT_W'(sat_max(V_CNT_W));
    localparam logic [F_CNT_W-1:0] F_MAX = F_CNT_W'(sat_max(F_CNT_W));
    localparam logic [H_CNT_W-1:0] H_ONE = H_CNT_W'(1);
    localparam logic [V_CNT_W-1:0] V_ONE = V_CNT_W'(1);
    localparam logic [F_CNT_W-1:0] F_ONE = F_CNT_W'(1);
    localparam int unsigned        STB_W = $clog2(STABLE_LINES + 1);
    localparam logic [STB_W-1:0]   STB_MAX = STB_W'(STABLE_LINES);
    localparam logic [STB_W-1:0]   STB_ONE = STB_W'(1);

    logic               hs_rise, hs_fall, vs_rise;
    logic [H_CNT_W-1:0] hcnt;
    logic [V_CNT_W-1:0] lcnt;
    logic [F_CNT_W-1:0] fcnt;
    logic [STB_W-1:0]   stable_ctr, stable_nxt;
    logic [V_CNT_W-1:0] flen, flen_prev, flen_max;
    logic               fid_prev;
    logic               armed;
    logic               in_tol;
    logic               fid_change;

    sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW)) u_hs_det (
        .clk      (PCLK_in),
        .reset    (reset),
        .sync_raw (HSYNC_in),
        .rise     (hs_rise),
        .fall     (hs_fall)
    );

    sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW)) u_vs_det (
        .clk      (PCLK_in),
        .reset    (reset),
        .sync_raw (VSYNC_in),
        .rise     (vs_rise),
        .fall     ()
    );

    always_comb begin
        in_tol = abs_diff(32'(hcnt), 32'(hperiod)) <= H_TOL;
        if (!in_tol) begin
            stable_nxt = '0;
        end else if (stable_ctr == STB_MAX) begin
            stable_nxt = stable_ctr;
        end else begin
            stable_nxt = stable_ctr + STB_ONE;
        end
        // A line edge landing on the VSYNC edge still belongs to the ending frame.
        flen       = (hs_rise && (lcnt != V_MAX)) ? (lcnt + V_ONE) : lcnt;
        flen_max   = (flen > flen_prev) ? flen : flen_prev;
        fid_change = FID_in != fid_prev;
    end

    always_ff @(posedge PCLK_in) begin
        if (reset) begin
            hcnt       <= '0;
            lcnt       <= '0;
            fcnt       <= '0;
            stable_ctr <= '0;
            flen_prev  <= '0;
            fid_prev   <= 1'b0;
            armed      <= 1'b0;
            hperiod    <= '0;
            hswidth    <= '0;
            vtotal     <= '0;
            pcnt_frame <= '0;
            ilace_flag <= 1'b0;
            h_unstable <= 1'b1;
            v_valid    <= 1'b0;
            frame_stb  <= 1'b0;
        end else begin
            frame_stb <= 1'b0;

            // Horizontal: period, stability and line count.
            if (hs_rise) begin
                hcnt       <= H_ONE;
                hperiod    <= hcnt;
                stable_ctr <= stable_nxt;
                h_unstable <= stable_nxt < STB_MAX;
                if (lcnt != V_MAX) begin
                    lcnt <= lcnt + V_ONE;
                end
            end else if (hcnt != H_MAX) begin
                hcnt <= hcnt + H_ONE;
            end else begin
                // No HSYNC for a full counter span: line timing lost.
                hperiod    <= '0;
                stable_ctr <= '0;
                h_unstable <= 1'b1;
            end

            if (hs_fall) begin
                hswidth <= hcnt;
            end

            if (vs_rise) begin
                fcnt <= F_ONE;
            end else if (fcnt != F_MAX) begin
                fcnt <= fcnt + F_ONE;
            end

            // Vertical: the first edge after reset/timeout only arms.
            if (vs_rise) begin
                lcnt     <= '0;
                fid_prev <= FID_in;
                armed    <= 1'b1;
                if (armed) begin
                    ilace_flag <= fid_change;
                    vtotal     <= fid_change ? flen_max : flen;
                    flen_prev  <= flen;
                    pcnt_frame <= fcnt;
                    frame_stb  <= 1'b1;
                    v_valid    <= 1'b1;
                end else begin
                    flen_prev <= '0;
                end
            end else if (lcnt == V_MAX) begin
                v_valid    <= 1'b0;
                vtotal     <= '0;
                ilace_flag <= 1'b0;
                armed      <= 1'b0;
                fid_prev   <= 1'b0;
                flen_prev  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tvp_sync_meas.sv
// Directed bench for tvp_sync_meas: progressive, jitter, interlace, coincident
// edges, H/V timeouts and mid-frame reset, each with hand-computed expectations.
module tb_tvp_sync_meas;

    logic        PCLK_in = 1'b0;
    logic        reset;
    logic        HSYNC_in;
    logic        VSYNC_in;
    logic        FID_in;
    logic [11:0] hperiod;
    logic [11:0] hswidth;
    logic [10:0] vtotal;
    logic [19:0] pcnt_frame;
    logic        ilace_flag;
    logic        h_unstable;
    logic        v_valid;
    logic        frame_stb;

    int vec_cnt = 0;
    int err_cnt = 0;
    int stb_cnt = 0;

    tvp_sync_meas dut (
        .PCLK_in    (PCLK_in),
        .reset      (reset),
        .HSYNC_in   (HSYNC_in),
        .VSYNC_in   (VSYNC_in),
        .FID_in     (FID_in),
        .hperiod    (hperiod),
        .hswidth    (hswidth),
        .vtotal     (vtotal),
        .pcnt_frame (pcnt_frame),
        .ilace_flag (ilace_flag),
        .h_unstable (h_unstable),
        .v_valid    (v_valid),
        .frame_stb  (frame_stb)
    );

    always #5 PCLK_in = ~PCLK_in;

    always @(negedge PCLK_in) begin
        if (frame_stb === 1'b1) stb_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge PCLK_in);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        HSYNC_in = 1'b1;
        VSYNC_in = 1'b1;
        FID_in   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One line: HSYNC low for w PCLKs; VSYNC low for the whole line when vs is set.
    task automatic send_line(input int len, input int w, input bit vs, input bit fid);
        for (int i = 0; i < len; i++) begin
            HSYNC_in = (i < w) ? 1'b0 : 1'b1;
            VSYNC_in = vs ? 1'b0 : 1'b1;
            FID_in   = fid;
            tick();
        end
    endtask

    task automatic send_field(input int n, input int len, input int w, input bit fid);
        for (int i = 0; i < n; i++) send_line(len, w, i == 0, fid);
    endtask

    task automatic test_reset();
        apply_reset();
        vec_cnt++; if (hperiod !== 12'd0) begin err_cnt++; $display("FAIL rst_hperiod: got %0d want 0", hperiod); end
        vec_cnt++; if (hswidth !== 12'd0) begin err_cnt++; $display("FAIL rst_hswidth: got %0d want 0", hswidth); end
        vec_cnt++; if (vtotal !== 11'd0) begin err_cnt++; $display("FAIL rst_vtotal: got %0d want 0", vtotal); end
        vec_cnt++; if (pcnt_frame !== 20'd0) begin err_cnt++; $display("FAIL rst_pcnt: got %0d want 0", pcnt_frame); end
        vec_cnt++; if (ilace_flag !== 1'b0) begin err_cnt++; $display("FAIL rst_ilace: got %b want 0", ilace_flag); end
        vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL rst_h_unstable: got %b want 1", h_unstable); end
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_v_valid: got %b want 0", v_valid); end
        vec_cnt++; if (frame_stb !== 1'b0) begin err_cnt++; $display("FAIL rst_frame_stb: got %b want 0", frame_stb); end
    endtask

    // 858-PCLK lines, 62-PCLK HSYNC, VSYNC every 4 lines (3432 PCLK per frame).
    task automatic test_progressive();
        int s0;
        apply_reset();
        s0 = stb_cnt;
        for (int i = 0; i < 13; i++) begin
            send_line(858, 62, (i % 4) == 0, 1'b0);
            if (i == 3) begin
                vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL prog_arm_valid: got %b want 0", v_valid); end
                vec_cnt++; if (stb_cnt - s0 !== 0) begin err_cnt++; $display("FAIL prog_arm_stb: got %0d pulses want 0", stb_cnt - s0); end
            end
            if (i == 4) begin
                vec_cnt++; if (vtotal !== 11'd4) begin err_cnt++; $display("FAIL prog_vtotal: got %0d want 4", vtotal); end
                vec_cnt++; if (pcnt_frame !== 20'd3432) begin err_cnt++; $display("FAIL prog_pcnt: got %0d want 3432", pcnt_frame); end
                vec_cnt++; if (ilace_flag !== 1'b0) begin err_cnt++; $display("FAIL prog_ilace: got %b want 0", ilace_flag); end
                vec_cnt++; if (v_valid !== 1'b1) begin err_cnt++; $display("FAIL prog_v_valid: got %b want 1", v_valid); end
                vec_cnt++; if (stb_cnt - s0 !== 1) begin err_cnt++; $display("FAIL prog_stb_once: got %0d pulses want 1", stb_cnt - s0); end
            end
            if (i == 8) begin
                vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL prog_unstable_7: got %b want 1", h_unstable); end
            end
            if (i == 9) begin
                vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL prog_stable_8: got %b want 0", h_unstable); end
                vec_cnt++; if (hperiod !== 12'd858) begin err_cnt++; $display("FAIL prog_hperiod: got %0d want 858", hperiod); end
                vec_cnt++; if (hswidth !== 12'd62) begin err_cnt++; $display("FAIL prog_hswidth: got %0d want 62", hswidth); end
            end
            if (i == 12) begin
                vec_cnt++; if (stb_cnt - s0 !== 3) begin err_cnt++; $display("FAIL prog_stb_total: got %0d pulses want 3", stb_cnt - s0); end
                vec_cnt++; if (pcnt_frame !== 20'd3432) begin err_cnt++; $display("FAIL prog_pcnt2: got %0d want 3432", pcnt_frame); end
            end
        end
    endtask

    // Continues from the stable 858 state left by test_progressive.
    task automatic test_jitter();
        int lens [6] = '{859, 860, 858, 859, 860, 858};
        int prev = 858;
        for (int i = 0; i < 6; i++) begin
            send_line(lens[i], 62, 1'b0, 1'b0);
            vec_cnt++; if (hperiod !== 12'(prev)) begin err_cnt++; $display("FAIL jit_hperiod[%0d]: got %0d want %0d", i, hperiod, prev); end
            vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL jit_stable[%0d]: got %b want 0", i, h_unstable); end
            prev = lens[i];
        end
        send_line(864, 62, 1'b0, 1'b0);
        vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL jit_pre_long: got %b want 0", h_unstable); end
        for (int k = 1; k <= 10; k++) begin
            send_line(858, 62, 1'b0, 1'b0);
            if (k == 1) begin
                vec_cnt++; if (hperiod !== 12'd864) begin err_cnt++; $display("FAIL jit_long_period: got %0d want 864", hperiod); end
                vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL jit_long_unstable: got %b want 1", h_unstable); end
            end
            if (k == 9) begin
                vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL jit_recover_7: got %b want 1", h_unstable); end
            end
            if (k == 10) begin
                vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL jit_recover_8: got %b want 0", h_unstable); end
            end
        end
    endtask

    // Fields of 263/262 short lines, FID toggling per field.
    task automatic test_interlace();
        apply_reset();
        send_field(263, 4, 1, 1'b0);
        vec_cnt++; if (ilace_flag !== 1'b0) begin err_cnt++; $display("FAIL il_arm_flag: got %b want 0", ilace_flag); end
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL il_arm_valid: got %b want 0", v_valid); end
        send_field(262, 4, 1, 1'b1);
        vec_cnt++; if (ilace_flag !== 1'b1) begin err_cnt++; $display("FAIL il_f1_flag: got %b want 1", ilace_flag); end
        vec_cnt++; if (vtotal !== 11'd263) begin err_cnt++; $display("FAIL il_f1_vtotal: got %0d want 263", vtotal); end
        vec_cnt++; if (pcnt_frame !== 20'd1052) begin err_cnt++; $display("FAIL il_f1_pcnt: got %0d want 1052", pcnt_frame); end
        vec_cnt++; if (hswidth !== 12'd1) begin err_cnt++; $display("FAIL il_hswidth: got %0d want 1", hswidth); end
        send_field(263, 4, 1, 1'b0);
        vec_cnt++; if (ilace_flag !== 1'b1) begin err_cnt++; $display("FAIL il_f2_flag: got %b want 1", ilace_flag); end
        vec_cnt++; if (vtotal !== 11'd263) begin err_cnt++; $display("FAIL il_f2_vtotal: got %0d want 263", vtotal); end
        vec_cnt++; if (pcnt_frame !== 20'd1048) begin err_cnt++; $display("FAIL il_f2_pcnt: got %0d want 1048", pcnt_frame); end
        send_field(262, 4, 1, 1'b1);
        vec_cnt++; if (vtotal !== 11'd263) begin err_cnt++; $display("FAIL il_f3_vtotal: got %0d want 263", vtotal); end
    endtask

    // VSYNC edge lands with an HSYNC edge while lcnt = 524.
    task automatic test_coincident();
        apply_reset();
        send_field(525, 4, 1, 1'b0);
        send_field(525, 4, 1, 1'b0);
        vec_cnt++; if (vtotal !== 11'd525) begin err_cnt++; $display("FAIL co_vtotal1: got %0d want 525", vtotal); end
        vec_cnt++; if (pcnt_frame !== 20'd2100) begin err_cnt++; $display("FAIL co_pcnt: got %0d want 2100", pcnt_frame); end
        send_field(525, 4, 1, 1'b0);
        vec_cnt++; if (vtotal !== 11'd525) begin err_cnt++; $display("FAIL co_vtotal2: got %0d want 525", vtotal); end
        vec_cnt++; if (ilace_flag !== 1'b0) begin err_cnt++; $display("FAIL co_ilace: got %b want 0", ilace_flag); end
    endtask

    task automatic test_h_timeout();
        apply_reset();
        for (int i = 0; i < 10; i++) send_line(100, 10, 1'b0, 1'b0);
        vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL ht_stable: got %b want 0", h_unstable); end
        HSYNC_in = 1'b1;
        for (int i = 0; i < 3995; i++) tick();
        vec_cnt++; if (hperiod !== 12'd100) begin err_cnt++; $display("FAIL ht_before: got %0d want 100", hperiod); end
        vec_cnt++; if (h_unstable !== 1'b0) begin err_cnt++; $display("FAIL ht_before_unst: got %b want 0", h_unstable); end
        tick();
        vec_cnt++; if (hperiod !== 12'd0) begin err_cnt++; $display("FAIL ht_period: got %0d want 0", hperiod); end
        vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL ht_unstable: got %b want 1", h_unstable); end
        send_line(100, 10, 1'b0, 1'b0);
        vec_cnt++; if (hperiod !== 12'd4095) begin err_cnt++; $display("FAIL ht_sat_period: got %0d want 4095", hperiod); end
        send_line(100, 10, 1'b0, 1'b0);
        vec_cnt++; if (hperiod !== 12'd100) begin err_cnt++; $display("FAIL ht_resume: got %0d want 100", hperiod); end
        vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL ht_resume_unst: got %b want 1", h_unstable); end
    endtask

    task automatic test_v_timeout();
        int s0;
        apply_reset();
        send_field(8, 4, 1, 1'b0);
        send_field(8, 4, 1, 1'b0);
        for (int i = 0; i < 2039; i++) send_line(4, 1, 1'b0, 1'b0);
        vec_cnt++; if (v_valid !== 1'b1) begin err_cnt++; $display("FAIL vt_before_valid: got %b want 1", v_valid); end
        vec_cnt++; if (vtotal !== 11'd8) begin err_cnt++; $display("FAIL vt_before_vtotal: got %0d want 8", vtotal); end
        send_line(4, 1, 1'b0, 1'b0);
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL vt_valid: got %b want 0", v_valid); end
        vec_cnt++; if (vtotal !== 11'd0) begin err_cnt++; $display("FAIL vt_vtotal: got %0d want 0", vtotal); end
        s0 = stb_cnt;
        send_field(8, 4, 1, 1'b0);
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL vt_rearm_valid: got %b want 0", v_valid); end
        vec_cnt++; if (stb_cnt - s0 !== 0) begin err_cnt++; $display("FAIL vt_rearm_stb: got %0d pulses want 0", stb_cnt - s0); end
        send_field(8, 4, 1, 1'b0);
        vec_cnt++; if (v_valid !== 1'b1) begin err_cnt++; $display("FAIL vt_again_valid: got %b want 1", v_valid); end
        vec_cnt++; if (vtotal !== 11'd8) begin err_cnt++; $display("FAIL vt_again_vtotal: got %0d want 8", vtotal); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        send_field(8, 4, 1, 1'b0);
        send_field(8, 4, 1, 1'b0);
        send_field(3, 4, 1, 1'b0);
        vec_cnt++; if (v_valid !== 1'b1) begin err_cnt++; $display("FAIL mr_pre_valid: got %b want 1", v_valid); end
        HSYNC_in = 1'b0;
        VSYNC_in = 1'b1;
        tick();
        HSYNC_in = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        vec_cnt++; if (hperiod !== 12'd0) begin err_cnt++; $display("FAIL mr_hperiod: got %0d want 0", hperiod); end
        vec_cnt++; if (hswidth !== 12'd0) begin err_cnt++; $display("FAIL mr_hswidth: got %0d want 0", hswidth); end
        vec_cnt++; if (vtotal !== 11'd0) begin err_cnt++; $display("FAIL mr_vtotal: got %0d want 0", vtotal); end
        vec_cnt++; if (pcnt_frame !== 20'd0) begin err_cnt++; $display("FAIL mr_pcnt: got %0d want 0", pcnt_frame); end
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL mr_v_valid: got %b want 0", v_valid); end
        vec_cnt++; if (h_unstable !== 1'b1) begin err_cnt++; $display("FAIL mr_h_unstable: got %b want 1", h_unstable); end
        send_field(8, 4, 1, 1'b0);
        vec_cnt++; if (v_valid !== 1'b0) begin err_cnt++; $display("FAIL mr_arm_valid: got %b want 0", v_valid); end
        send_field(8, 4, 1, 1'b0);
        vec_cnt++; if (v_valid !== 1'b1) begin err_cnt++; $display("FAIL mr_valid: got %b want 1", v_valid); end
        vec_cnt++; if (vtotal !== 11'd8) begin err_cnt++; $display("FAIL mr_vtotal2: got %0d want 8", vtotal); end
    endtask

    initial begin
        test_reset();
        test_progressive();
        test_jitter();
        test_interlace();
        test_coincident();
        test_h_timeout();
        test_v_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
